// File: rtl/serial_seq_pkg.sv
// Shared types for the bit-serial logic processor command sequencer.
// cmd_t carries its load data at SEQ_DATA_W bits; the sequencer's DATA_W defaults to it.
package serial_seq_pkg;

  localparam int SEQ_DATA_W = 4;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    LDA  = 2'd1,
    LDB  = 2'd2,
    EXEC = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    op_e                   op;
    logic [SEQ_DATA_W-1:0] din;
    logic [2:0]            f;
    logic [1:0]            r;
  } cmd_t;

endpackage

// File: rtl/seq_cmd_fifo.sv
// First-word-fall-through command FIFO; head is valid whenever empty is low.
module seq_cmd_fifo
  import serial_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  cmd_t                   push_data,
  input  logic                   pop,
  output cmd_t                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/serial_op_sequencer.sv
// Command sequencer for the 4-bit bit-serial logic datapath: pops queued LDA/LDB/EXEC/NOP
// commands and drives registered load strobes, shift enable and F/R selects.
module serial_op_sequencer
  import serial_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_din,
  input  logic [2:0]        cmd_f,
  input  logic [1:0]        cmd_r,
  output logic              Ld_A,
  output logic              Ld_B,
  output logic [DATA_W-1:0] Din_out,
  output logic              Shift_En,
  output logic [2:0]        F_out,
  output logic [1:0]        R_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ops_done
);

  localparam int FCNT_W = $clog2(DEPTH) + 1;
  localparam int SH_W   = $clog2(DATA_W + 1);

  state_e            state;
  state_e            state_nxt;
  cmd_t              push_data;
  cmd_t              head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [FCNT_W-1:0] fcount;
  logic [FCNT_W-1:0] fcount_nxt;
  logic [SH_W-1:0]   sh_cnt;
  logic [SH_W-1:0]   sh_cnt_nxt;
  logic              ld_a_nxt;
  logic              ld_b_nxt;
  logic              busy_nxt;

  assign cmd_ready = !full && Reset;
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    push_data     = '0;
    push_data.op  = op_e'(cmd_op);
    push_data.din = cmd_din;
    push_data.f   = cmd_f;
    push_data.r   = cmd_r;
  end

  seq_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst_n    (Reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (fcount),
    .full     (full),
    .empty    (empty)
  );

  // Next state plus the next value of every registered output.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    sh_cnt_nxt = sh_cnt;
    ld_a_nxt   = 1'b0;
    ld_b_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          case (head.op)
            LDA: begin
              state_nxt = LOAD;
              ld_a_nxt  = 1'b1;
            end
            LDB: begin
              state_nxt = LOAD;
              ld_b_nxt  = 1'b1;
            end
            EXEC: begin
              state_nxt  = SHIFT;
              sh_cnt_nxt = SH_W'(DATA_W - 1);
            end
            default: state_nxt = DONE;
          endcase
        end
      end
      LOAD:  state_nxt = DONE;
      SHIFT: begin
        if (sh_cnt == '0) state_nxt = DONE;
        else              sh_cnt_nxt = sh_cnt - 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    fcount_nxt = fcount + FCNT_W'(push) - FCNT_W'(pop);
    busy_nxt   = (state_nxt != IDLE) || (fcount_nxt != '0);
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      sh_cnt   <= '0;
      Ld_A     <= 1'b0;
      Ld_B     <= 1'b0;
      Shift_En <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ops_done <= '0;
      Din_out  <= '0;
      F_out    <= '0;
      R_out    <= '0;
    end else begin
      state    <= state_nxt;
      sh_cnt   <= sh_cnt_nxt;
      Ld_A     <= ld_a_nxt;
      Ld_B     <= ld_b_nxt;
      Shift_En <= (state_nxt == SHIFT);
      done     <= (state_nxt == DONE);
      busy     <= busy_nxt;
      if (state_nxt == DONE) ops_done <= ops_done + 1'b1;
      if (pop) begin
        Din_out <= head.din;
        if (head.op == EXEC) begin
          F_out <= head.f;
          R_out <= head.r;
        end
      end
    end
  end

endmodule

// File: doc/serial_op_sequencer.md
Name: serial_op_sequencer

Overview:
- Command-driven control unit for the 4-bit bit-serial logic processor datapath (A/B shift registers, F-selected logic function, R-selected routing).
- Accepts queued commands (load A, load B, execute) over a valid/ready handshake.
- Drives the datapath's load strobes, shift enable and F/R selects cycle-accurately, replacing manual LoadA/LoadB/Execute button sequencing.
- Sits between a host/test driver and the register-unit/compute/router datapath.

Parameters:
- DATA_W, 4, datapath register width; also the shift count per EXEC.
- DEPTH, 4, command FIFO depth (power of two, >=2).
- CNT_W, 8, width of the completed-command counter.

Ports:
- Clk  in  1  system clock; all logic is rising-edge.
- Reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  2  0=NOP, 1=LDA, 2=LDB, 3=EXEC.
- cmd_din  in  DATA_W  load data (LDA/LDB only).
- cmd_f  in  3  logic function select (EXEC only).
- cmd_r  in  2  routing select (EXEC only).
- Ld_A  out  1  load A strobe to the register unit.
- Ld_B  out  1  load B strobe to the register unit.
- Din_out  out  DATA_W  data to the register unit.
- Shift_En  out  1  shift both registers this cycle.
- F_out  out  3  function select to the compute unit.
- R_out  out  2  routing select to the router.
- busy  out  1  state != IDLE or FIFO non-empty.
- done  out  1  1-cycle pulse when a command retires.
- ops_done  out  CNT_W  count of retired commands.

Behaviour:
- Reset (Reset==0 at a Clk edge): state=IDLE, FIFO emptied, all outputs 0 (cmd_ready=0 during reset), ops_done=0. Takes effect the cycle after sampling. Reset mid-SHIFT aborts the command with no done pulse.
- Handshake:
  - Push occurs when cmd_valid && cmd_ready at an edge.
  - cmd_ready = (count < DEPTH) && Reset; it does not look ahead to a same-cycle pop.
  - Simultaneous push and pop when count==DEPTH cannot occur, because ready is 0.
  - Push and pop in the same cycle at 0<count<DEPTH leaves count unchanged.
- FIFO: registered, first-word-fall-through; commands retire in strict arrival order; pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE:
    - FIFO non-empty: pop and latch {op,din,f,r} into the current-command register.
    - Next state: LOAD for LDA/LDB, SHIFT for EXEC, DONE for NOP.
    - FIFO empty: stay in IDLE.
  - LOAD (1 cycle): Ld_A=1 (LDA) or Ld_B=1 (LDB); Din_out=latched din. Next state DONE.
  - SHIFT:
    - Shift_En=1 for exactly DATA_W consecutive cycles.
    - F_out/R_out hold the latched f/r throughout, and until the next EXEC is latched.
    - A down-counter loads DATA_W-1 on entry; exit to DONE when the counter==0 and shifting.
  - DONE (1 cycle): done=1, ops_done+=1 (wraps 2^CNT_W-1 -> 0). Next state IDLE.
- Output defaults:
  - Ld_A, Ld_B, Shift_En are 0 outside their states.
  - Din_out holds the last latched din.
  - All outputs are registered (glitch-free to the datapath).
- Per-command latency from pop edge to done pulse:
  - LDA/LDB: done on the 2nd cycle after pop.
  - EXEC: done on the DATA_W+1-th cycle after pop.
  - NOP: done on the 1st cycle after pop.
  - Back-to-back throughput: one IDLE cycle between commands.
- Illegal conditions: none; every 2-bit op is defined.
- cmd_din/f/r fields irrelevant to an op are latched but ignored.

Decomposition:
- Package serial_seq_pkg:
  - op_e enum (NOP, LDA, LDB, EXEC).
  - state_e enum (IDLE, LOAD, SHIFT, DONE).
  - cmd_t packed struct {op, din, f, r}.
  - Default DATA_W constant.
- One sub-module: seq_cmd_fifo (parameterized DEPTH, payload cmd_t; push/pop/count/full/empty).
- The FSM, counters and output registers live in serial_op_sequencer.

Test Plan:
- Reset held 3 cycles while cmd_valid=1 -> cmd_ready=0, all outputs 0, ops_done=0, nothing enqueued.
- Push LDA din=4'hB, LDB din=4'h2, EXEC f=3'b010 r=2'b10 -> Ld_A pulse with Din_out=B; then Ld_B pulse with Din_out=2; then Shift_En high exactly 4 cycles with F_out=010, R_out=10; 3 done pulses; ops_done=3. With the datapath attached: A=4'h9, B=4'h2.
- Push 6 EXECs back-to-back from idle -> cmd_ready low whenever count==4; all 6 accepted with none lost; 24 total Shift_En cycles; 6 done pulses in order; busy falls 1 cycle after the last done.
- EXEC f=110 r=01 followed by EXEC r=11 -> F_out/R_out change only on the second latch; never mid-shift.
- Reset asserted on the 2nd SHIFT cycle with 2 commands queued -> Shift_En=0 next cycle; FIFO empty; no done pulse; ops_done=0.
- Pre-load ops_done to 255 via 255 NOPs, then 1 more NOP -> ops_done wraps to 0; done still pulses.
